// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for the MIPS-lite core: IR latch, decode, IF/DCD/EXE/MEM/WB sequencing.
// Latency: 2 cycles (j/jal/jr/illegal), 3 (beq), 4 (R/ori/lui/sw), 5 (lw) with mem_rdy high.
// Backpressure: MEM holds with all strobes low until mem_rdy; reset forces every strobe low.
module mc_ctrl #(
  parameter logic [31:0] IR_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_in,
  input  logic             mem_rdy,
  output logic [31:0]      ir,
  output logic [2:0]       state,
  output logic             irwr,
  output logic             enpc,
  output logic             npc_sel,
  output logic             jsome,
  output logic             jr,
  output logic             regwr,
  output logic             memwr,
  output logic [1:0]       regdst,
  output logic             alusrc,
  output logic [1:0]       aluop,
  output logic             extop,
  output logic [1:0]       memtoreg,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DCD = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      ir_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  // Decode is purely combinational from the latched instruction word.
  logic [5:0] op, funct;
  logic       is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic       is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

  assign op       = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign is_r     = (op == 6'b000000);
  assign is_addu  = is_r && (funct == 6'b100001);
  assign is_subu  = is_r && (funct == 6'b100011);
  assign is_jr    = is_r && (funct == 6'b001000);
  assign is_ori   = (op == 6'b001101);
  assign is_lui   = (op == 6'b001111);
  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_beq   = (op == 6'b000100);
  assign is_j     = (op == 6'b000010);
  assign is_jal   = (op == 6'b000011);
  assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lui |
                    is_lw | is_sw | is_beq | is_j | is_jal;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // IR, sticky illegal flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q      <= IR_RESET;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (irwr) ir_q <= instr_in;
      if (state_q == S_DCD && !is_legal) illegal_q <= 1'b1;
      if (enpc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  state_d = S_DCD;
      S_DCD: state_d = (is_j || is_jal || is_jr || !is_legal) ? S_IF : S_EXE;
      S_EXE: begin
        if (is_beq)           state_d = S_IF;
        else if (is_lw || is_sw) state_d = S_MEM;
        else                  state_d = S_WB;
      end
      S_MEM: if (mem_rdy) state_d = is_sw ? S_IF : S_WB;
      S_WB:  state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Strobes and datapath selects; selects stay zero in IF, strobes zero under reset.
  always_comb begin
    irwr     = 1'b0;
    enpc     = 1'b0;
    npc_sel  = 1'b0;
    jsome    = 1'b0;
    jr       = 1'b0;
    regwr    = 1'b0;
    memwr    = 1'b0;
    regdst   = 2'd0;
    alusrc   = 1'b0;
    aluop    = 2'd0;
    extop    = 1'b0;
    memtoreg = 2'd0;
    if (state_q != S_IF) begin
      if (is_addu) regdst = 2'd1;
      if (is_subu) begin regdst = 2'd1; aluop = 2'd1; end
      if (is_ori)  begin alusrc = 1'b1; aluop = 2'd2; end
      if (is_lui)  begin alusrc = 1'b1; aluop = 2'd3; end
      if (is_lw)   begin alusrc = 1'b1; extop = 1'b1; memtoreg = 2'd1; end
      if (is_sw)   begin alusrc = 1'b1; extop = 1'b1; end
      if (is_beq)  begin aluop = 2'd1; extop = 1'b1; end
      if (is_jal)  begin regdst = 2'd2; memtoreg = 2'd2; end
    end
    case (state_q)
      S_IF: irwr = 1'b1;
      S_DCD: begin
        if (is_j)   begin jsome = 1'b1; enpc = 1'b1; end
        if (is_jal) begin jsome = 1'b1; regwr = 1'b1; enpc = 1'b1; end
        if (is_jr)  begin jr = 1'b1; enpc = 1'b1; end
        if (!is_legal) enpc = 1'b1;
      end
      S_EXE: if (is_beq) begin npc_sel = 1'b1; enpc = 1'b1; end
      S_MEM: begin
        aluop  = 2'd0;
        alusrc = 1'b1;
        extop  = 1'b1;
        if (mem_rdy && is_sw) begin memwr = 1'b1; enpc = 1'b1; end
      end
      S_WB: begin regwr = 1'b1; enpc = 1'b1; end
      default: ;
    endcase
    if (reset) begin
      irwr    = 1'b0;
      enpc    = 1'b0;
      npc_sel = 1'b0;
      jsome   = 1'b0;
      jr      = 1'b0;
      regwr   = 1'b0;
      memwr   = 1'b0;
    end
  end

  assign ir        = ir_q;
  assign state     = state_q;
  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: reset, lui, stalled lw, beq, jal, illegal+addu, sw, jr, reset in MEM.
// Inputs change and outputs are sampled just after the falling edge.
// Every comparison goes through chk; one summary line at the end.
module tb_mc_ctrl;
  logic        clk;
  logic        reset;
  logic [31:0] instr_in;
  logic        mem_rdy;
  logic [31:0] ir;
  logic [2:0]  state;
  logic        irwr, enpc, npc_sel, jsome, jr, regwr, memwr;
  logic [1:0]  regdst, aluop, memtoreg;
  logic        alusrc, extop, illegal;
  logic [31:0] instr_cnt;

  int n_chk = 0;
  int n_err = 0;

  mc_ctrl #(.IR_RESET(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .mem_rdy(mem_rdy),
    .ir(ir), .state(state), .irwr(irwr), .enpc(enpc), .npc_sel(npc_sel),
    .jsome(jsome), .jr(jr), .regwr(regwr), .memwr(memwr), .regdst(regdst),
    .alusrc(alusrc), .aluop(aluop), .extop(extop), .memtoreg(memtoreg),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic wr;
    logic done;

    // Reset: strobes forced low, architectural state cleared.
    reset = 1'b1; instr_in = 32'h3C01_1234; mem_rdy = 1'b1;
    @(negedge clk); #1;
    chk("rst_irwr", irwr, 0);
    chk("rst_enpc", enpc, 0);
    chk("rst_state", state, 0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_illegal", illegal, 0);

    // 1. lui: IF, DCD, EXE, WB.
    reset = 1'b0; #1;
    chk("lui_if_irwr", irwr, 1);
    chk("lui_if_aluop", aluop, 0);
    tick;
    chk("lui_dcd_state", state, 1);
    chk("lui_ir", ir, 32'h3C01_1234);
    chk("lui_dcd_enpc", enpc, 0);
    tick;
    chk("lui_exe_state", state, 2);
    tick;
    chk("lui_wb_state", state, 4);
    chk("lui_wb_regwr", regwr, 1);
    chk("lui_wb_enpc", enpc, 1);
    chk("lui_wb_aluop", aluop, 3);
    chk("lui_wb_alusrc", alusrc, 1);
    chk("lui_wb_regdst", regdst, 0);
    tick;
    chk("lui_cnt", instr_cnt, 1);
    chk("lui_back_if", state, 0);

    // 2. lw with mem_rdy low for 3 cycles.
    instr_in = 32'h8C22_0004; mem_rdy = 1'b0;
    tick; tick; tick;
    for (int k = 0; k < 3; k++) begin
      chk("lw_mem_hold_state", state, 3);
      chk("lw_mem_hold_enpc", enpc, 0);
      chk("lw_mem_hold_memwr", memwr, 0);
      tick;
    end
    mem_rdy = 1'b1; #1;
    chk("lw_mem_rdy_state", state, 3);
    chk("lw_mem_rdy_enpc", enpc, 0);
    chk("lw_mem_extop", extop, 1);
    tick;
    chk("lw_wb_state", state, 4);
    chk("lw_wb_memtoreg", memtoreg, 1);
    chk("lw_wb_regwr", regwr, 1);
    chk("lw_wb_enpc", enpc, 1);
    tick;
    chk("lw_cnt", instr_cnt, 2);

    // 3. beq: completes in EXE, never writes.
    instr_in = 32'h1022_0003;
    n = 0; wr = 1'b0; done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      n++;
      wr = wr | regwr | memwr;
      if (state == 3'd2) begin
        chk("beq_exe_npc_sel", npc_sel, 1);
        chk("beq_exe_aluop", aluop, 1);
        chk("beq_exe_enpc", enpc, 1);
      end
      if (enpc) done = 1'b1;
      else tick;
    end
    chk("beq_done", done, 1);
    chk("beq_cycles", n, 3);
    chk("beq_no_write", wr, 0);
    tick;
    chk("beq_back_if", state, 0);

    // 4. jal: everything happens in DCD.
    instr_in = 32'h0C00_0C00;
    tick;
    chk("jal_dcd_state", state, 1);
    chk("jal_jsome", jsome, 1);
    chk("jal_regwr", regwr, 1);
    chk("jal_regdst", regdst, 2);
    chk("jal_memtoreg", memtoreg, 2);
    chk("jal_enpc", enpc, 1);
    tick;
    chk("jal_back_if", state, 0);
    chk("jal_cnt", instr_cnt, 4);

    // 5. Illegal opcode then addu, from a fresh reset.
    reset = 1'b1;
    tick;
    reset = 1'b0; instr_in = 32'hFC00_0000; #1;
    chk("ill_rst_cnt", instr_cnt, 0);
    chk("ill_rst_flag", illegal, 0);
    tick;
    chk("ill_dcd_enpc", enpc, 1);
    chk("ill_dcd_regwr", regwr, 0);
    tick;
    chk("ill_state_if", state, 0);
    chk("ill_flag", illegal, 1);
    chk("ill_cnt", instr_cnt, 1);
    instr_in = 32'h0022_1821;
    tick;
    chk("addu_dcd_enpc", enpc, 0);
    tick;
    chk("addu_exe_state", state, 2);
    tick;
    chk("addu_wb_state", state, 4);
    chk("addu_wb_regdst", regdst, 1);
    chk("addu_wb_alusrc", alusrc, 0);
    chk("addu_wb_aluop", aluop, 0);
    chk("addu_wb_regwr", regwr, 1);
    chk("addu_wb_illegal", illegal, 1);
    tick;
    chk("addu_cnt", instr_cnt, 2);
    chk("addu_illegal_sticky", illegal, 1);

    // sw completing normally in MEM.
    instr_in = 32'hAC22_0008; mem_rdy = 1'b1;
    tick; tick; tick;
    chk("sw_mem_state", state, 3);
    chk("sw_mem_memwr", memwr, 1);
    chk("sw_mem_enpc", enpc, 1);
    chk("sw_mem_regwr", regwr, 0);
    tick;
    chk("sw_cnt", instr_cnt, 3);

    // jr: DCD only.
    instr_in = 32'h03E0_0008;
    tick;
    chk("jr_dcd_jr", jr, 1);
    chk("jr_dcd_enpc", enpc, 1);
    chk("jr_dcd_jsome", jsome, 0);
    tick;
    chk("jr_cnt", instr_cnt, 4);

    // 6. sw abandoned by reset in MEM.
    instr_in = 32'hAC22_0008; mem_rdy = 1'b0;
    tick; tick; tick;
    chk("swr_mem_state", state, 3);
    chk("swr_mem_wait_memwr", memwr, 0);
    mem_rdy = 1'b1; reset = 1'b1; #1;
    chk("swr_rst_memwr", memwr, 0);
    chk("swr_rst_enpc", enpc, 0);
    tick;
    reset = 1'b0; #1;
    chk("swr_state", state, 0);
    chk("swr_cnt", instr_cnt, 0);
    chk("swr_illegal", illegal, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
